// File: rtl/pwm_peripheral.sv
// pwm_peripheral: drives 16 pins low, constantly high, or with a shared 256-step PWM waveform.
// The PWM counter advances once every PRESCALE clk cycles; a full period is 256*PRESCALE clk.
// Optional feature macro: PWM_DUTY_SHADOW_EN. When defined, the duty cycle is latched at each
// period start so that writes never disturb a running period. When undefined, the live input
// drives the compare directly.
module pwm_peripheral #(
    parameter int unsigned PRESCALE = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start,
    output logic [7:0]  pwm_count
);

    // Prescaler needs at least one bit even when PRESCALE is 1.
    localparam int unsigned PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PreW-1:0] PreMax = PreW'(PRESCALE - 1);

    logic [PreW-1:0] pre_cnt_q, pre_cnt_d;
    logic [7:0]      pwm_cnt_q, pwm_cnt_d;
    logic [15:0]     out_q, out_d;
    logic            period_start_q;
    logic            tick, wrap;
    logic [7:0]      duty_eff;
    logic            pwm_raw;
    logic [15:0]     en_out, en_pwm;

    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    // Prescaler and PWM counter next state; wrap marks the 255 -> 0 step.
    always_comb begin
        tick      = (pre_cnt_q == PreMax);
        wrap      = tick && (pwm_cnt_q == 8'hFF);
        pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
        pwm_cnt_d = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    end

`ifdef PWM_DUTY_SHADOW_EN
    logic [7:0] duty_shadow_q;

    // Latch the duty at the period boundary so a write never truncates the running period.
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_shadow_q <= 8'h00;
        end else if (wrap) begin
            duty_shadow_q <= pwm_duty_cycle;
        end
    end

    assign duty_eff = duty_shadow_q;
`else
    assign duty_eff = pwm_duty_cycle;
`endif

    // Duty compare and pin drive; 0xFF is special-cased to give a true 100 % level.
    always_comb begin
        pwm_raw = (duty_eff == 8'hFF) ? 1'b1 : (pwm_cnt_q < duty_eff);
        out_d   = en_out & (~en_pwm | {16{pwm_raw}});
    end

    // State registers; reset wins over everything, including a pending wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_q      <= '0;
            pwm_cnt_q      <= 8'h00;
            out_q          <= 16'h0000;
            period_start_q <= 1'b0;
        end else begin
            pre_cnt_q      <= pre_cnt_d;
            pwm_cnt_q      <= pwm_cnt_d;
            out_q          <= out_d;
            period_start_q <= wrap;
        end
    end

    assign out          = out_q;
    assign period_start = period_start_q;
    assign pwm_count    = pwm_cnt_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed bench for pwm_peripheral: instance a uses PRESCALE=2, instance b uses PRESCALE=1.
// Expected values that depend on PWM_DUTY_SHADOW_EN are selected by the same macro.
module tb_pwm_peripheral;

`ifdef PWM_DUTY_SHADOW_EN
    localparam bit Shadow = 1'b1;
`else
    localparam bit Shadow = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        a_rst, b_rst;
    logic [15:0] a_eo, a_ep, b_eo, b_ep;
    logic [7:0]  a_duty, b_duty;
    logic [15:0] a_out, b_out;
    logic        a_ps, b_ps;
    logic [7:0]  a_cnt, b_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pwm_peripheral #(.PRESCALE(2)) u_dut_a (
        .clk             (clk),
        .rst             (a_rst),
        .en_reg_out_7_0  (a_eo[7:0]),
        .en_reg_out_15_8 (a_eo[15:8]),
        .en_reg_pwm_7_0  (a_ep[7:0]),
        .en_reg_pwm_15_8 (a_ep[15:8]),
        .pwm_duty_cycle  (a_duty),
        .out             (a_out),
        .period_start    (a_ps),
        .pwm_count       (a_cnt)
    );

    pwm_peripheral #(.PRESCALE(1)) u_dut_b (
        .clk             (clk),
        .rst             (b_rst),
        .en_reg_out_7_0  (b_eo[7:0]),
        .en_reg_out_15_8 (b_eo[15:8]),
        .en_reg_pwm_7_0  (b_ep[7:0]),
        .en_reg_pwm_15_8 (b_ep[15:8]),
        .pwm_duty_cycle  (b_duty),
        .out             (b_out),
        .period_start    (b_ps),
        .pwm_count       (b_cnt)
    );

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Step until instance a shows period_start, giving up after 600 edges.
    task automatic wait_ps_a(input string tag);
        int n;
        n = 0;
        do begin
            step(1);
            n++;
        end while (!a_ps && n < 600);
        check(tag, 32'(a_ps), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hi, ps, ps_at, bad;

        // Reset and test 1: PRESCALE=2, duty 0x80 on pin 0.
        a_rst = 1'b1; b_rst = 1'b1;
        a_eo = 16'h0001; a_ep = 16'h0001; a_duty = 8'h80;
        b_eo = 16'h0001; b_ep = 16'h0001; b_duty = 8'h03;
        step(2);
        check("rst_out", 32'(a_out), 32'h0);
        check("rst_count", 32'(a_cnt), 32'h0);
        check("rst_period_start", 32'(a_ps), 32'h0);
        a_rst = 1'b0;

        hi = 0; ps = 0; ps_at = 0;
        for (int k = 1; k <= 512; k++) begin
            step(1);
            hi += int'(a_out[0]);
            if (a_ps) begin ps++; ps_at = k; end
            if (k == 300) check("t1_count_mid", 32'(a_cnt), 32'd150);
        end
        check("t1_high_p1", 32'(hi), Shadow ? 32'd0 : 32'd256);
        check("t1_ps_count_p1", 32'(ps), 32'd1);
        check("t1_ps_at_p1", 32'(ps_at), 32'd512);

        hi = 0; ps = 0; ps_at = 0;
        for (int k = 1; k <= 512; k++) begin
            step(1);
            hi += int'(a_out[0]);
            if (a_ps) begin ps++; ps_at = k; end
        end
        check("t1_high_p2", 32'(hi), 32'd256);
        check("t1_ps_count_p2", 32'(ps), 32'd1);
        check("t1_ps_at_p2", 32'(ps_at), 32'd512);

        // Test 2: plain enables, no PWM.
        a_eo = 16'hFFFF; a_ep = 16'h0000;
        step(1);
        check("t2_all_on", 32'(a_out), 32'hFFFF);
        bad = 0;
        for (int k = 0; k < 600; k++) begin
            step(1);
            if (a_out !== 16'hFFFF) bad++;
        end
        check("t2_all_on_steady", 32'(bad), 32'd0);
        a_eo = 16'h00FF;
        step(1);
        check("t2_low_byte", 32'(a_out), 32'h00FF);

        // Test 3: duty extremes on all pins.
        a_eo = 16'hFFFF; a_ep = 16'hFFFF; a_duty = 8'h00;
        wait_ps_a("t3_wait_ps_zero");
        check("t3_wrap_count", 32'(a_cnt), 32'h0);
        check("t3_wrap_out", 32'(a_out), 32'h0);
        bad = 0;
        for (int k = 0; k < 1536; k++) begin
            step(1);
            if (a_out !== 16'h0000) bad++;
        end
        check("t3_duty00_low", 32'(bad), 32'd0);
        a_duty = 8'hFF;
        step(2);
        check("t3_duty_ff_before_load", 32'(a_out), Shadow ? 32'h0 : 32'hFFFF);
        wait_ps_a("t3_wait_ps_ff");
        bad = 0;
        for (int k = 0; k < 512; k++) begin
            step(1);
            if (a_out !== 16'hFFFF) bad++;
        end
        check("t3_duty_ff_high", 32'(bad), 32'd0);

        // Test 4: duty 0x40 -> 0xC0 at pwm_count 100.
        a_eo = 16'h0001; a_ep = 16'h0001; a_duty = 8'h40;
        wait_ps_a("t4_wait_ps");
        hi = 0;
        for (int k = 0; k < 200; k++) begin
            step(1);
            hi += int'(a_out[0]);
        end
        check("t4_high_before_write", 32'(hi), 32'd128);
        check("t4_count_at_write", 32'(a_cnt), 32'd100);
        a_duty = 8'hC0;
        step(1);
        check("t4_pin_after_write", 32'(a_out[0]), Shadow ? 32'd0 : 32'd1);
        hi = int'(a_out[0]);
        for (int k = 0; k < 311; k++) begin
            step(1);
            hi += int'(a_out[0]);
        end
        check("t4_high_rest_of_period", 32'(hi), Shadow ? 32'd0 : 32'd184);
        hi = 0;
        for (int k = 0; k < 512; k++) begin
            step(1);
            hi += int'(a_out[0]);
        end
        check("t4_high_next_period", 32'(hi), 32'd384);

        // Test 5: reset mid-period at pwm_count 77.
        a_duty = 8'h80;
        step(154);
        check("t5_count_before_rst", 32'(a_cnt), 32'd77);
        check("t5_pin_before_rst", 32'(a_out[0]), 32'd1);
        a_rst = 1'b1;
        step(1);
        check("t5_rst_out", 32'(a_out), 32'h0);
        check("t5_rst_count", 32'(a_cnt), 32'h0);
        check("t5_rst_ps", 32'(a_ps), 32'h0);
        a_rst = 1'b0;
        step(1);
        check("t5_phase_edge1", 32'(a_cnt), 32'd0);
        step(1);
        check("t5_phase_edge2", 32'(a_cnt), 32'd1);
        step(1);
        check("t5_pin_after_rst", 32'(a_out[0]), Shadow ? 32'd0 : 32'd1);

        // Test 6: PRESCALE=1, duty 0x03.
        check("t6_rst_out", 32'(b_out), 32'h0);
        check("t6_rst_count", 32'(b_cnt), 32'h0);
        b_rst = 1'b0;
        bad = 0; ps = 0; ps_at = 0; hi = 0;
        for (int k = 1; k <= 512; k++) begin
            step(1);
            if (b_cnt !== 8'(k)) bad++;
            if (b_ps) begin ps++; if (ps_at == 0) ps_at = k; end
            if (k == 256) begin
                check("t6_high_p1", 32'(hi), Shadow ? 32'd0 : 32'd3);
                hi = 0;
            end else begin
                hi += int'(b_out[0]);
            end
        end
        check("t6_count_every_clk", 32'(bad), 32'd0);
        check("t6_ps_count", 32'(ps), 32'd2);
        check("t6_ps_first_at", 32'(ps_at), 32'd256);
        check("t6_high_p2", 32'(hi + int'(b_out[0])), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
